mdio_link_monitor: RTL and testbench
====================================

// Module: mdio_link_monitor
// PURPOSE
//  Polls PHY link status over MDIO once PHY configuration is done.
//  Drives the cmd_* request side of mdio_master with read commands and consumes its data_out stream.
//  Publishes decoded link_up/speed/duplex to the MAC/UDP datapath.
//  Top level muxes the mdio_master command port: mdio_config until its done=1, then this block.
// PARAMETERS
//  PHY_ADDR        5'h03          MDIO address of the PHY
//  SPEC_REG        5'h11          vendor PHY-specific status register address
//  POLL_CYCLES     24'd1_000_000  sys_clk cycles between poll starts (>=1)
//  TIMEOUT_CYCLES  16'd4096       max cycles from read-command accept to its data
// PORTS
//  sys_clk          in   1   system clock; all logic on its rising edge
//  sys_clk_rst_n    in   1   asynchronous, active-low reset
//  cfg_done         in   1   PHY configuration finished (from mdio_config done)
//  cmd_phy_addr     out  5   to mdio_master: PHY address, always PHY_ADDR
//  cmd_reg_addr     out  5   to mdio_master: register address
//  cmd_data         out  16  to mdio_master: write data, always 16'h0000
//  cmd_opcode       out  2   to mdio_master: opcode, always 2'b10 (read)
//  cmd_valid        out  1   to mdio_master: command request
//  cmd_ready        in   1   from mdio_master: command accepted
//  resp_data        in   16  from mdio_master data_out: read data
//  resp_valid       in   1   from mdio_master data_out_valid: read data valid
//  resp_ready       out  1   to mdio_master data_out_ready; constant 1
//  link_up          out  1   resolved link status
//  speed            out  2   00=10M, 01=100M, 10=1000M
//  full_duplex      out  1   1 = full duplex
//  status_valid     out  1   1-cycle pulse: status outputs updated
//  link_change      out  1   1-cycle pulse coincident with status_valid when link_up toggles
//  mdio_timeout     out  1   sticky: a read timed out; cleared only by reset
// BEHAVIOUR
//  Reset values: all outputs 0 except the constant outputs (resp_ready, cmd_phy_addr, cmd_opcode, cmd_data).
//  State machine states: IDLE, WAIT, RD_BMSR, WT_BMSR, RD_SPEC, WT_SPEC, UPDATE.
//  IDLE: leave when cfg_done=1. Go to RD_BMSR immediately, with no delay for the first poll.
//  RD_x: cmd_valid=1 with cmd_reg_addr = 5'h01 (BMSR) or SPEC_REG.
//   Fields stay stable while cmd_valid is high.
//   On the cycle cmd_valid&cmd_ready: drop cmd_valid next cycle and go to WT_x.
//   cmd_valid is never withdrawn before that handshake, even if cfg_done falls.
//  WT_x: 16-bit timeout counter runs from command accept.
//   On resp_valid: capture resp_data. Advance WT_BMSR->RD_SPEC, or WT_SPEC->UPDATE.
//   Counter reaching TIMEOUT_CYCLES-1 with no resp_valid: set mdio_timeout and go to WAIT.
//   On timeout, status outputs are unchanged and status_valid is not pulsed.
//  resp_valid seen outside WT_x is discarded.
//   resp_valid and timeout expiry in the same cycle: the data wins.
//  UPDATE (1 cycle), decoding from captured regs:
//   lk  = BMSR[2] & SPEC[11] & SPEC[10]
//   spd = SPEC[15:14]
//   dup = SPEC[13]
//   If spd==2'b11 (reserved): force lk=0 and hold speed/full_duplex at their old values.
//   Else: register speed=spd and full_duplex=dup.
//   link_up<=lk. status_valid pulses. link_change pulses if lk != previous link_up. Go to WAIT.
//  WAIT: 24-bit poll counter loaded when the read of BMSR is accepted.
//   Next RD_BMSR starts exactly POLL_CYCLES cycles after that acceptance.
//   If a poll overruns (still busy at expiry), start the next poll immediately on reaching WAIT.
//  cfg_done=0 is checked only in WAIT and at exit from UPDATE/timeout.
//   It sends the FSM to IDLE and clears link_up (link_change pulses if link_up was 1).
//   An in-flight transaction always completes first.
//  Outputs change only in UPDATE or on the IDLE return, never mid-poll.
//  Async reset mid-transaction: immediate return to IDLE, cmd_valid low, all status cleared.
//   mdio_master is reset by the same reset, so there is no stale response.
// TESTING
//  1. cfg_done=1; BFM returns BMSR=16'h796D, SPEC=16'hAC00 -> speed=2'b10, full_duplex=1, link_up=1; status_valid and link_change pulse once.
//  2. cmd_ready held low 50 cycles during RD_BMSR -> cmd_valid held high with reg_addr 5'h01 stable; exactly one command accepted.
//  3. POLL_CYCLES=100: BMSR-read accepts are exactly 100 cycles apart; second poll SPEC=16'h2000 -> link_up 1->0, link_change pulse.
//  4. SPEC=16'hEC00 (reserved speed) -> link_up=0; speed/full_duplex unchanged.
//  5. No resp_valid for TIMEOUT_CYCLES -> mdio_timeout=1, no status_valid; next poll proceeds normally.
//  6. Assert sys_clk_rst_n=0 during WT_SPEC -> all outputs 0 same cycle; after release, no command until cfg_done=1.

Source files
------------

// File: rtl/mdio_link_monitor.sv
// mdio_link_monitor
//   Once PHY configuration has finished, polls the PHY over the mdio_master
//   command port. Each poll reads BMSR (reg 1), then the vendor-specific status
//   register. The result is decoded into link_up / speed / full_duplex for the
//   MAC/UDP datapath.
//
// Ports
//   sys_clk, sys_clk_rst_n   clock, asynchronous active-low reset
//   cfg_done                 PHY configuration finished; enables polling
//   cmd_*                    read-command request to mdio_master (valid/ready)
//   resp_*                   read-data stream from mdio_master (resp_ready = 1)
//   link_up, speed,          resolved link status; speed 00=10M 01=100M 10=1000M
//   full_duplex
//   status_valid             1-cycle pulse when the status outputs are updated
//   link_change              1-cycle pulse with status_valid when link_up toggles
//   mdio_timeout             sticky flag: a read got no data in time
module mdio_link_monitor #(
  parameter logic [4:0]  PHY_ADDR       = 5'h03,
  parameter logic [4:0]  SPEC_REG       = 5'h11,
  parameter logic [23:0] POLL_CYCLES    = 24'd1_000_000,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd4096
) (
  input  logic        sys_clk,
  input  logic        sys_clk_rst_n,
  input  logic        cfg_done,
  output logic [4:0]  cmd_phy_addr,
  output logic [4:0]  cmd_reg_addr,
  output logic [15:0] cmd_data,
  output logic [1:0]  cmd_opcode,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [15:0] resp_data,
  input  logic        resp_valid,
  output logic        resp_ready,
  output logic        link_up,
  output logic [1:0]  speed,
  output logic        full_duplex,
  output logic        status_valid,
  output logic        link_change,
  output logic        mdio_timeout
);

  localparam logic [4:0]  BMSR_REG     = 5'h01;
  localparam logic [23:0] POLL_RELOAD  = POLL_CYCLES - 24'd1;
  localparam logic [15:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 16'd1;

  typedef enum logic [2:0] {
    IDLE, WAIT, RD_BMSR, WT_BMSR, RD_SPEC, WT_SPEC, UPDATE
  } state_t;

  state_t      state_q, state_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [4:0]  cmd_reg_addr_q, cmd_reg_addr_d;
  logic        link_up_q, link_up_d;
  logic [1:0]  speed_q, speed_d;
  logic        full_duplex_q, full_duplex_d;
  logic        status_valid_q, status_valid_d;
  logic        link_change_q, link_change_d;
  logic        mdio_timeout_q, mdio_timeout_d;
  logic [15:0] bmsr_q, bmsr_d;
  logic [15:0] spec_q, spec_d;
  logic [23:0] poll_cnt_q, poll_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;

  logic accept;
  logic poll_due;
  logic lk;
  logic to_idle;
  logic unused_capture_bits;

  assign accept = cmd_valid_q & cmd_ready;
  // The poll counter is loaded with POLL_CYCLES-1 on the cycle after the BMSR
  // accept; leaving WAIT when it reads 1 (or 0 after an overrun) lands the
  // next RD_BMSR exactly POLL_CYCLES cycles after that accept.
  assign poll_due = (poll_cnt_q <= 24'd1);
  // A reserved speed code means the status register cannot be trusted.
  assign lk = bmsr_q[2] & spec_q[11] & spec_q[10] & (spec_q[15:14] != 2'b11);
  assign unused_capture_bits = ^{bmsr_q[15:3], bmsr_q[1:0], spec_q[9:0]};

  always_comb begin
    state_d        = state_q;
    cmd_valid_d    = cmd_valid_q;
    cmd_reg_addr_d = cmd_reg_addr_q;
    link_up_d      = link_up_q;
    speed_d        = speed_q;
    full_duplex_d  = full_duplex_q;
    status_valid_d = 1'b0;
    link_change_d  = 1'b0;
    mdio_timeout_d = mdio_timeout_q;
    bmsr_d         = bmsr_q;
    spec_d         = spec_q;
    poll_cnt_d     = (poll_cnt_q != 24'd0) ? poll_cnt_q - 24'd1 : 24'd0;
    to_cnt_d       = to_cnt_q;
    to_idle        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_done) begin
          state_d        = RD_BMSR;
          cmd_valid_d    = 1'b1;
          cmd_reg_addr_d = BMSR_REG;
        end
      end
      WAIT: begin
        if (!cfg_done) begin
          to_idle = 1'b1;
        end else if (poll_due) begin
          state_d        = RD_BMSR;
          cmd_valid_d    = 1'b1;
          cmd_reg_addr_d = BMSR_REG;
        end
      end
      RD_BMSR: begin
        if (accept) begin
          cmd_valid_d = 1'b0;
          state_d     = WT_BMSR;
          to_cnt_d    = 16'd0;
          poll_cnt_d  = POLL_RELOAD;
        end
      end
      WT_BMSR: begin
        to_cnt_d = to_cnt_q + 16'd1;
        // Data arriving on the expiry cycle still counts as a response.
        if (resp_valid) begin
          bmsr_d         = resp_data;
          state_d        = RD_SPEC;
          cmd_valid_d    = 1'b1;
          cmd_reg_addr_d = SPEC_REG;
        end else if (to_cnt_q == TIMEOUT_LAST) begin
          mdio_timeout_d = 1'b1;
          state_d        = WAIT;
          to_idle        = !cfg_done;
        end
      end
      RD_SPEC: begin
        if (accept) begin
          cmd_valid_d = 1'b0;
          state_d     = WT_SPEC;
          to_cnt_d    = 16'd0;
        end
      end
      WT_SPEC: begin
        to_cnt_d = to_cnt_q + 16'd1;
        if (resp_valid) begin
          spec_d  = resp_data;
          state_d = UPDATE;
        end else if (to_cnt_q == TIMEOUT_LAST) begin
          mdio_timeout_d = 1'b1;
          state_d        = WAIT;
          to_idle        = !cfg_done;
        end
      end
      UPDATE: begin
        link_up_d      = lk;
        link_change_d  = (lk != link_up_q);
        status_valid_d = 1'b1;
        if (spec_q[15:14] != 2'b11) begin
          speed_d       = spec_q[15:14];
          full_duplex_d = spec_q[13];
        end
        state_d = WAIT;
        to_idle = !cfg_done;
      end
      default: state_d = IDLE;
    endcase

    // Losing cfg_done drops the link; this is only reached between polls.
    if (to_idle) begin
      state_d        = IDLE;
      link_up_d      = 1'b0;
      link_change_d  = link_up_q;
      status_valid_d = status_valid_d | link_up_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_clk_rst_n) begin
    if (!sys_clk_rst_n) begin
      state_q        <= IDLE;
      cmd_valid_q    <= 1'b0;
      cmd_reg_addr_q <= 5'h00;
      link_up_q      <= 1'b0;
      speed_q        <= 2'b00;
      full_duplex_q  <= 1'b0;
      status_valid_q <= 1'b0;
      link_change_q  <= 1'b0;
      mdio_timeout_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_reg_addr_q <= cmd_reg_addr_d;
      link_up_q      <= link_up_d;
      speed_q        <= speed_d;
      full_duplex_q  <= full_duplex_d;
      status_valid_q <= status_valid_d;
      link_change_q  <= link_change_d;
      mdio_timeout_q <= mdio_timeout_d;
    end
  end

  // Captures and counters are always loaded before they are consulted.
  always_ff @(posedge sys_clk) begin
    bmsr_q     <= bmsr_d;
    spec_q     <= spec_d;
    poll_cnt_q <= poll_cnt_d;
    to_cnt_q   <= to_cnt_d;
  end

  assign cmd_phy_addr = PHY_ADDR;
  assign cmd_data     = 16'h0000;
  assign cmd_opcode   = 2'b10;
  assign resp_ready   = 1'b1;
  assign cmd_reg_addr = cmd_reg_addr_q;
  assign cmd_valid    = cmd_valid_q;
  assign link_up      = link_up_q;
  assign speed        = speed_q;
  assign full_duplex  = full_duplex_q;
  assign status_valid = status_valid_q;
  assign link_change  = link_change_q;
  assign mdio_timeout = mdio_timeout_q;

endmodule

// File: tb/tb_mdio_link_monitor.sv
module tb_mdio_link_monitor;

  localparam int POLL = 100;
  localparam int TMO  = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_done = 1'b0;
  logic        cmd_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [15:0] resp_data = 16'h0000;
  logic [4:0]  cmd_phy_addr;
  logic [4:0]  cmd_reg_addr;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_opcode;
  logic        cmd_valid;
  logic        resp_ready;
  logic        link_up;
  logic [1:0]  speed;
  logic        full_duplex;
  logic        status_valid;
  logic        link_change;
  logic        mdio_timeout;

  mdio_link_monitor #(
    .PHY_ADDR(5'h03),
    .SPEC_REG(5'h11),
    .POLL_CYCLES(24'd100),
    .TIMEOUT_CYCLES(16'd40)
  ) dut (
    .sys_clk(clk),
    .sys_clk_rst_n(rst_n),
    .cfg_done(cfg_done),
    .cmd_phy_addr(cmd_phy_addr),
    .cmd_reg_addr(cmd_reg_addr),
    .cmd_data(cmd_data),
    .cmd_opcode(cmd_opcode),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .resp_data(resp_data),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .link_up(link_up),
    .speed(speed),
    .full_duplex(full_duplex),
    .status_valid(status_valid),
    .link_change(link_change),
    .mdio_timeout(mdio_timeout)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Event bookkeeping: clock count, BMSR accept times, pulse counts.
  int unsigned cyc = 0;
  int unsigned acc_q[$];
  int sv_cnt = 0;
  int cmd_acc_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) begin
      cmd_acc_cnt <= cmd_acc_cnt + 1;
      if (cmd_reg_addr == 5'h01) acc_q.push_back(cyc);
    end
    if (status_valid) sv_cnt <= sv_cnt + 1;
  end

  // Reference model of the published link status.
  logic       exp_link = 1'b0;
  logic [1:0] exp_speed = 2'b00;
  logic       exp_dup = 1'b0;
  logic       exp_change = 1'b0;

  task automatic model_update(input logic [15:0] b, input logic [15:0] s);
    logic lk;
    lk = b[2] & s[11] & s[10];
    if (s[15:14] == 2'b11) begin
      lk = 1'b0;
    end else begin
      exp_speed = s[15:14];
      exp_dup   = s[13];
    end
    exp_change = (lk != exp_link);
    exp_link   = lk;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cmd(input string tag, input int budget);
    int n;
    n = 0;
    while (cmd_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, cmd_valid, 1);
  endtask

  // One full poll; BFM answers with b then s using the given delays.
  task automatic do_poll(input logic [15:0] b, input logic [15:0] s,
                         input int rdly_b, input int resp_b,
                         input int rdly_s, input int resp_s, input bit chk_space);
    int sv0;
    int acc0;
    sv0 = sv_cnt;
    wait_cmd("bmsr_cmd", 250);
    check("bmsr_reg", cmd_reg_addr, 5'h01);
    for (int i = 0; i < rdly_b; i++) begin
      tick();
      check("bmsr_hold_valid", cmd_valid, 1);
      check("bmsr_hold_reg", cmd_reg_addr, 5'h01);
    end
    acc0 = cmd_acc_cnt;
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("bmsr_one_accept", cmd_acc_cnt - acc0, 1);
    check("bmsr_valid_drop", cmd_valid, 0);
    if (chk_space) check("poll_spacing", acc_q[$] - acc_q[$-1], POLL);
    repeat (resp_b) tick();
    resp_data  = b;
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    resp_data  = 16'($urandom);
    wait_cmd("spec_cmd", 10);
    check("spec_reg", cmd_reg_addr, 5'h11);
    repeat (rdly_s) tick();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("spec_valid_drop", cmd_valid, 0);
    repeat (resp_s) tick();
    resp_data  = s;
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    tick();
    model_update(b, s);
    check("status_valid", status_valid, 1);
    check("link_change", link_change, exp_change);
    check("link_up", link_up, exp_link);
    check("speed", speed, exp_speed);
    check("full_duplex", full_duplex, exp_dup);
    tick();
    check("status_valid_pulse", status_valid, 0);
    check("link_change_pulse", link_change, 0);
    check("status_valid_count", sv_cnt - sv0, 1);
  endtask

  logic [15:0] rb;
  logic [15:0] rs;
  int          sv_snap;
  logic        seen;

  initial begin
    // Reset values
    repeat (3) tick();
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_reg", cmd_reg_addr, 0);
    check("rst_link_up", link_up, 0);
    check("rst_speed", speed, 0);
    check("rst_duplex", full_duplex, 0);
    check("rst_status_valid", status_valid, 0);
    check("rst_link_change", link_change, 0);
    check("rst_timeout", mdio_timeout, 0);
    check("const_phy_addr", cmd_phy_addr, 5'h03);
    check("const_opcode", cmd_opcode, 2'b10);
    check("const_data", cmd_data, 16'h0000);
    check("const_resp_ready", resp_ready, 1);
    rst_n = 1'b1;
    repeat (10) tick();
    check("idle_no_cmd", cmd_valid, 0);

    // Basic gigabit full-duplex link
    cfg_done = 1'b1;
    do_poll(16'h796D, 16'hAC00, 0, 3, 0, 3, 1'b0);
    check("t1_speed_1000", speed, 2'b10);
    check("t1_full_duplex", full_duplex, 1);
    check("t1_link_up", link_up, 1);

    // Command held off by cmd_ready for 50 cycles
    do_poll(16'h796D, 16'hAC00, 50, 2, 1, 2, 1'b0);

    // Poll spacing and link drop
    do_poll(16'h796D, 16'hAC00, 0, 4, 0, 4, 1'b1);
    do_poll(16'h796D, 16'h2000, 0, 5, 2, 5, 1'b1);
    check("t3_link_down", link_up, 0);

    // Reserved speed holds speed/duplex and forces link down
    do_poll(16'h796D, 16'h8C00, 0, 1, 0, 1, 1'b1);
    do_poll(16'h796D, 16'hEC00, 0, 1, 0, 1, 1'b1);
    check("t4_link_down", link_up, 0);
    check("t4_speed_held", speed, 2'b10);
    check("t4_duplex_held", full_duplex, 0);

    // Response on the last cycle before expiry is accepted
    do_poll(16'h796D, 16'hAC00, 0, TMO - 1, 0, TMO - 1, 1'b1);
    check("edge_no_timeout", mdio_timeout, 0);

    // Randomised polls
    for (int k = 0; k < 8; k++) begin
      rb = 16'($urandom);
      rs = 16'($urandom);
      if (k % 2 == 1) begin
        rb[2]     = 1'b1;
        rs[11:10] = 2'b11;
      end
      do_poll(rb, rs, 0, $urandom_range(0, 20), $urandom_range(0, 3),
              $urandom_range(0, 20), 1'b1);
    end

    // BMSR read with no response times out
    sv_snap = sv_cnt;
    wait_cmd("tmo_cmd", 250);
    check("tmo_reg", cmd_reg_addr, 5'h01);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check("tmo_spacing", acc_q[$] - acc_q[$-1], POLL);
    repeat (TMO - 1) tick();
    check("tmo_not_yet", mdio_timeout, 0);
    tick();
    check("tmo_set", mdio_timeout, 1);
    check("tmo_no_status", sv_cnt - sv_snap, 0);
    check("tmo_link_held", link_up, exp_link);
    check("tmo_speed_held", speed, exp_speed);
    do_poll(16'h796D, 16'hAC00, 0, 2, 0, 2, 1'b1);
    check("tmo_sticky", mdio_timeout, 1);

    // cfg_done falls while waiting between polls
    cfg_done = 1'b0;
    tick();
    check("drop_link_up", link_up, 0);
    check("drop_link_change", link_change, 1);
    exp_link = 1'b0;
    tick();
    check("drop_change_pulse", link_change, 0);
    seen = 1'b0;
    repeat (150) begin
      tick();
      if (cmd_valid) seen = 1'b1;
    end
    check("drop_idle_no_cmd", seen, 0);

    // Reset in the middle of the SPEC read
    cfg_done = 1'b1;
    do_poll(16'h796D, 16'hAC00, 0, 2, 0, 2, 1'b0);
    wait_cmd("rst_bmsr_cmd", 250);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    repeat (2) tick();
    resp_data  = 16'h796D;
    resp_valid = 1'b1;
    tick();
    resp_valid = 1'b0;
    wait_cmd("rst_spec_cmd", 10);
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_link_up", link_up, 0);
    check("mid_rst_speed", speed, 0);
    check("mid_rst_duplex", full_duplex, 0);
    check("mid_rst_timeout", mdio_timeout, 0);
    check("mid_rst_cmd_valid", cmd_valid, 0);
    check("mid_rst_status_valid", status_valid, 0);
    exp_link  = 1'b0;
    exp_speed = 2'b00;
    exp_dup   = 1'b0;
    cfg_done  = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (30) begin
      tick();
      if (cmd_valid) seen = 1'b1;
    end
    check("post_rst_no_cmd", seen, 0);
    cfg_done = 1'b1;
    do_poll(16'h796D, 16'h8C00, 0, 3, 0, 3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
